// File: rtl/float_to_int.sv
// Three-stage valid/ready pipeline converting IEEE-754 single to signed int32, round toward zero.
// Define FLOAT_TO_INT_FLAGS_EN to add the z_flags {invalid, inexact} output.
module float_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [31:0] z,
    output logic        z_valid,
`ifdef FLOAT_TO_INT_FLAGS_EN
    output logic [1:0]  z_flags,
`endif
    input  logic        z_ready
);

    logic v1_reg, v2_reg, v3_reg;
    logic ld1, ld2, ld3;

    // A stage accepts when it is empty or its successor is taking its current item.
    assign ld3     = !v3_reg || z_ready;
    assign ld2     = !v2_reg || ld3;
    assign ld1     = !v1_reg || ld2;
    assign a_ready = ld1;
    assign z_valid = v3_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            if (ld1) v1_reg <= a_valid;
            if (ld2) v2_reg <= v1_reg;
            if (ld3) v3_reg <= v2_reg;
        end
    end

    // ---------------- S1: unpack and classify ----------------
    logic        s1_sign_reg, s1_sign_next;
    logic [7:0]  s1_exp_reg, s1_exp_next;
    logic [23:0] s1_mant_reg, s1_mant_next;
    logic        s1_nan_reg, s1_nan_next;

    always_comb begin
        s1_sign_next = a[31];
        s1_exp_next  = a[30:23];
        s1_mant_next = {(a[30:23] != 8'd0), a[22:0]};
        s1_nan_next  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign_reg <= 1'b0;
            s1_exp_reg  <= 8'd0;
            s1_mant_reg <= 24'd0;
            s1_nan_reg  <= 1'b0;
        end else if (ld1 && a_valid) begin
            s1_sign_reg <= s1_sign_next;
            s1_exp_reg  <= s1_exp_next;
            s1_mant_reg <= s1_mant_next;
            s1_nan_reg  <= s1_nan_next;
        end
    end

    // ---------------- S2: align magnitude ----------------
    logic [8:0]  e_diff;
    logic        e_neg, e_in_range, e_big, is_min_int;
    logic [54:0] shifted;
    logic        s2_sign_reg, s2_sign_next;
    logic [31:0] s2_mag_reg, s2_mag_next;
    logic        s2_nan_reg, s2_nan_next;
    logic        s2_sat_reg, s2_sat_next;

    always_comb begin
        e_diff      = {1'b0, s1_exp_reg} - 9'd127;
        e_neg       = e_diff[8];
        e_in_range  = !e_neg && (e_diff < 9'd31);
        e_big       = !e_neg && !e_in_range;
        shifted     = {31'd0, s1_mant_reg} << e_diff[4:0];
        // -2^31 is the only e=31 value that is representable.
        is_min_int  = s1_sign_reg && (s1_exp_reg == 8'd158) && (s1_mant_reg[22:0] == 23'd0);
        s2_sign_next = s1_sign_reg;
        s2_nan_next  = s1_nan_reg;
        s2_sat_next  = e_big && !is_min_int && !s1_nan_reg;
        s2_mag_next  = 32'd0;
        if (e_in_range)
            s2_mag_next = shifted[54:23];
        else if (is_min_int)
            s2_mag_next = 32'h8000_0000;
    end

`ifdef FLOAT_TO_INT_FLAGS_EN
    logic s2_inexact_reg, s2_inexact_next;

    always_comb begin
        s2_inexact_next = 1'b0;
        if (e_neg)
            s2_inexact_next = |s1_mant_reg;
        else if (e_in_range)
            s2_inexact_next = |shifted[22:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            s2_inexact_reg <= 1'b0;
        else if (ld2 && v1_reg)
            s2_inexact_reg <= s2_inexact_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sign_reg <= 1'b0;
            s2_mag_reg  <= 32'd0;
            s2_nan_reg  <= 1'b0;
            s2_sat_reg  <= 1'b0;
        end else if (ld2 && v1_reg) begin
            s2_sign_reg <= s2_sign_next;
            s2_mag_reg  <= s2_mag_next;
            s2_nan_reg  <= s2_nan_next;
            s2_sat_reg  <= s2_sat_next;
        end
    end

    // ---------------- S3: sign and saturate ----------------
    logic [31:0] z_reg, z_next;

    always_comb begin
        if (s2_nan_reg)
            z_next = 32'h8000_0000;
        else if (s2_sat_reg)
            z_next = s2_sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (s2_sign_reg)
            z_next = -s2_mag_reg;
        else
            z_next = s2_mag_reg;
    end

    always_ff @(posedge clk) begin
        if (rst)
            z_reg <= 32'd0;
        else if (ld3 && v2_reg)
            z_reg <= z_next;
    end

    assign z = z_reg;

`ifdef FLOAT_TO_INT_FLAGS_EN
    logic [1:0] z_flags_reg, z_flags_next;

    always_comb begin
        z_flags_next = {s2_nan_reg || s2_sat_reg, s2_inexact_reg && !s2_nan_reg && !s2_sat_reg};
    end

    always_ff @(posedge clk) begin
        if (rst)
            z_flags_reg <= 2'b00;
        else if (ld3 && v2_reg)
            z_flags_reg <= z_flags_next;
    end

    assign z_flags = z_flags_reg;
`endif

endmodule

// File: tb/tb_float_to_int.sv
// Directed and random-stream bench for float_to_int; flag checks apply when FLOAT_TO_INT_FLAGS_EN is defined.
module tb_float_to_int;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] z;
    logic        z_valid;
    logic        z_ready;
`ifdef FLOAT_TO_INT_FLAGS_EN
    logic [1:0]  z_flags;
`endif

    int checks   = 0;
    int failures = 0;

    float_to_int dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .z       (z),
        .z_valid (z_valid),
`ifdef FLOAT_TO_INT_FLAGS_EN
        .z_flags (z_flags),
`endif
        .z_ready (z_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] exp);
`ifdef FLOAT_TO_INT_FLAGS_EN
        checks++;
        assert (z_flags === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, z_flags, exp);
        end
`else
        if (exp === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    // Independent model: {invalid, inexact, z}
    function automatic logic [33:0] ref_f2i(input logic [31:0] x);
        logic        s, inv, inex;
        int          ex;
        longint      m, val;
        logic [31:0] r;
        s    = x[31];
        ex   = int'(x[30:23]);
        m    = (ex == 0) ? longint'(x[22:0]) : longint'({1'b1, x[22:0]});
        inv  = 1'b0;
        inex = 1'b0;
        r    = 32'd0;
        if (ex == 255 && x[22:0] != 23'd0) begin
            r = 32'h8000_0000; inv = 1'b1;
        end else if (ex >= 159) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; inv = 1'b1;
        end else begin
            if (ex >= 150) begin
                val = m << (ex - 150);
            end else if (ex >= 127) begin
                val  = m >> (150 - ex);
                inex = ((val << (150 - ex)) != m);
            end else begin
                val  = 0;
                inex = (m != 0);
            end
            if (s) val = -val;
            if (val > 64'sd2147483647) begin
                r = 32'h7FFF_FFFF; inv = 1'b1; inex = 1'b0;
            end else if (val < -64'sd2147483648) begin
                r = 32'h8000_0000; inv = 1'b1; inex = 1'b0;
            end else begin
                r = val[31:0];
            end
        end
        return {inv, inex, r};
    endfunction

    // Call at posedge+1 with an empty pipeline: one item, checked cycle by cycle.
    task automatic send_one(input string tag, input logic [31:0] fa, input logic [31:0] ez, input logic [1:0] ef);
        a = fa; a_valid = 1'b1; z_ready = 1'b1;
        #1 chk1({tag, "/a_ready"}, a_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk1({tag, "/lat1"}, z_valid, 1'b0);
        @(posedge clk); #1;
        chk1({tag, "/lat2"}, z_valid, 1'b0);
        @(posedge clk); #1;
        chk1({tag, "/valid"}, z_valid, 1'b1);
        chk32({tag, "/z"}, z, ez);
        chk_flags({tag, "/flags"}, ef);
        @(posedge clk); #1;
        chk1({tag, "/drain"}, z_valid, 1'b0);
    endtask

    logic [31:0] bp_vals [4];
    logic [31:0] exp_q [$];
    logic [1:0]  expf_q [$];
    logic [31:0] cur;
    logic [33:0] r;
    int          sent, recv, cyc;
    logic        acc, ret;

    initial begin
        rst = 1'b1; a = 32'd0; a_valid = 1'b0; z_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk1("reset/z_valid", z_valid, 1'b0);
        chk32("reset/z", z, 32'd0);
        chk1("reset/a_ready", a_ready, 1'b1);
        chk_flags("reset/flags", 2'b00);
        @(posedge clk); #1;

        send_one("one",     32'h3F80_0000, 32'h0000_0001, 2'b00);
        send_one("neg3",    32'hC040_0000, 32'hFFFF_FFFD, 2'b00);
        send_one("2p5",     32'h4020_0000, 32'h0000_0002, 2'b01);
        send_one("m0p5",    32'hBF00_0000, 32'h0000_0000, 2'b01);
        send_one("negzero", 32'h8000_0000, 32'h0000_0000, 2'b00);
        send_one("pow31",   32'h4F00_0000, 32'h7FFF_FFFF, 2'b10);
        send_one("minint",  32'hCF00_0000, 32'h8000_0000, 2'b00);
        send_one("nan",     32'h7FC0_0000, 32'h8000_0000, 2'b10);
        send_one("neginf",  32'hFF80_0000, 32'h8000_0000, 2'b10);
        send_one("maxexact",32'h4EFF_FFFF, 32'h7FFF_FF80, 2'b00);
        send_one("denorm",  32'h0000_0001, 32'h0000_0000, 2'b01);

        // Backpressure: three accepts fill the pipe, the fourth waits.
        bp_vals[0] = 32'h3F80_0000; bp_vals[1] = 32'h4000_0000;
        bp_vals[2] = 32'h4040_0000; bp_vals[3] = 32'h4080_0000;
        z_ready = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = bp_vals[i];
            #1 chk1($sformatf("bp/a_ready%0d", i), a_ready, (i < 3));
            @(posedge clk); #1;
        end
        chk1("bp/stall_valid", z_valid, 1'b1);
        chk32("bp/stall_z", z, 32'd1);
        chk1("bp/stall_ready", a_ready, 1'b0);
        z_ready = 1'b1;
        #1 chk1("bp/release_ready", a_ready, 1'b1);
        chk32("bp/z1", z, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b0;
            chk1($sformatf("bp/v%0d", i), z_valid, 1'b1);
            chk32($sformatf("bp/z%0d", i), z, i);
        end
        @(posedge clk); #1;
        chk1("bp/empty", z_valid, 1'b0);

        // Reset with two items in flight and a third presented on the reset edge.
        z_ready = 1'b1; a_valid = 1'b1; a = 32'h40A0_0000;
        @(posedge clk); #1;
        a = 32'h40C0_0000;
        @(posedge clk); #1;
        rst = 1'b1; a = 32'h4100_0000;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0;
        chk1("rst/z_valid", z_valid, 1'b0);
        chk32("rst/z", z, 32'd0);
        chk1("rst/a_ready", a_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1($sformatf("rst/stale%0d", i), z_valid, 1'b0);
        end
        send_one("rst_seven", 32'h40E0_0000, 32'h0000_0007, 2'b00);

        // Random stream with random consumer stalls.
        sent = 0; recv = 0; cyc = 0;
        cur = 32'd0;
        while (recv < 1000 && cyc < 20000) begin
            if (sent < 1000 && !a_valid) begin
                case ($urandom_range(0, 9))
                    0:       cur = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom)};
                    1:       cur = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
                    2:       cur = {$urandom_range(0, 1) == 1, 8'($urandom_range(150, 160)), 23'd0};
                    default: cur = {$urandom_range(0, 1) == 1, 8'($urandom_range(110, 165)), 23'($urandom)};
                endcase
                a = cur;
                a_valid = 1'b1;
            end
            z_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = a_valid && a_ready;
            ret = z_valid && z_ready;
            if (ret) begin
                chk32($sformatf("stream/z%0d", recv), z, exp_q.pop_front());
                chk_flags($sformatf("stream/f%0d", recv), expf_q.pop_front());
                recv++;
            end
            if (acc) begin
                r = ref_f2i(a);
                exp_q.push_back(r[31:0]);
                expf_q.push_back(r[33:32]);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) a_valid = 1'b0;
            cyc++;
        end
        chk32("stream/received", recv, 32'd1000);
        chk32("stream/leftover", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
